fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch stage that sits directly upstream of decode and the immediate extender. It owns the fetch PC, issues in-order word reads to instruction memory, and buffers returned words in a DEPTH-entry FIFO. It presents `{instr, pc}` to decode with a valid/ready handshake; decode slices `instr[25:0]` for immediate extension. Execute redirects it on taken branches and jumps, which flushes all buffered and in-flight words.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- DEPTH, 4, FIFO entries and maximum outstanding requests; legal range 2..16.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  word address of request; always 4-aligned.
- imem_rsp_valid  in  1  read data valid; responses return in request order, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  execute redirect strobe, one cycle.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored, treated as 0.
- id_valid  out  1  head entry valid.
- id_ready  in  1  decode accepts head.
- id_instr  out  32  head instruction word.
- id_pc  out  32  PC of head instruction.

## Operation
- State: fetch_pc (32), FIFO of DEPTH entries of {instr, pc}, count (0..DEPTH), inflight (0..DEPTH), discard (0..DEPTH), pc FIFO for in-flight addresses (or equivalent tag).
- Reset: fetch_pc=RESET_PC, count=inflight=discard=0. While rst=1: imem_req_valid=0, id_valid=0. id_instr/id_pc=0.
- Issue: imem_req_valid = !rst && !redirect_valid && (count + inflight < DEPTH). imem_addr=fetch_pc. On accept: fetch_pc += 4, modulo 2^32 (0xFFFF_FFFC wraps to 0); inflight++.
- Response: on imem_rsp_valid: inflight--. If discard>0, discard-- and drop the word. Otherwise push {imem_rsp_data, pc of the matching request}. Credit rule guarantees no push when full; a push while full is an assertion failure.
- Dequeue: id_valid = (count>0). Pop on id_valid && id_ready. id_instr/id_pc come from head storage (registered, no combinational path from imem_rsp_*).
- Simultaneous push+pop: count unchanged, ordering preserved.
- Redirect (redirect_valid=1): same edge fetch_pc={redirect_pc[31:2],2'b00}, count=0 (the pop in that cycle is still honoured by decode, but its entry is gone either way). discard = inflight after this cycle's response/accept accounting, excluding the response arriving this cycle, which is dropped. No request issued in the redirect cycle.
- Redirect while discard>0: discard accumulates all still-in-flight requests; never exceeds DEPTH.
- Back-to-back redirects: the last one wins.

## Timing
- Request accepted in cycle N with 1-cycle memory: rsp in N+1, id_valid in N+2.
- First request issued in the first cycle with rst=0.
- Steady state with 1-cycle memory, id_ready=1, DEPTH>=2: one instruction per cycle.
- Redirect in cycle R: id_valid=0 in R+1; first new request in R+1; first new instruction visible at R+3 with 1-cycle memory.
- id_ready=0: FIFO fills; issue stops once count+inflight=DEPTH; resumes the cycle after a pop frees a slot.
- rst asserted mid-operation: all state cleared at that edge; pending memory responses after reset are discarded only if memory is also reset. The memory is reset with the core.

## Test plan
- Reset release, RESET_PC=0x100, 1-cycle memory returning addr as data, id_ready=1 -> id_pc 0x100,0x104,0x108 on consecutive cycles, first id_valid 2 cycles after first request.
- id_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, id_valid held, id_pc stays 0x100; release gives 0x100..0x10C in order with no gaps or duplicates.
- Redirect to 0x2002 with 3 requests in flight -> those 3 responses dropped, id_valid=0 in the next cycle, next delivered id_pc=0x2000.
- Redirect in the same cycle as a pop and a response -> no stale word delivered; discard count correct (assertion: inflight==0 ⇒ discard==0).
- imem_req_ready toggling randomly, 3-cycle memory latency -> sequence strictly +4, no drops, count never exceeds 4.
- Redirect to 0xFFFF_FFF8 -> PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues in-order word reads, and buffers
// returned words with their PCs for decode. Redirects flush buffered and in-flight words.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t          DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0] q_instr [DEPTH];
  logic [31:0] q_pc    [DEPTH];
  logic [31:0] f_pc    [DEPTH];

  ptr_t        q_head, q_tail, f_head, f_tail;
  cnt_t        count, inflight, discard;
  logic [31:0] fetch_pc;
  logic [CW:0] occupancy;
  logic        accept, push, pop;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == ptr_t'(DEPTH - 1)) return '0;
    return p + ptr_t'(1);
  endfunction

  always_comb begin
    occupancy      = {1'b0, count} + {1'b0, inflight};
    imem_req_valid = !rst && !redirect_valid && (occupancy < DEPTH_W);
    imem_addr      = fetch_pc;
    accept         = imem_req_valid && imem_req_ready;
    id_valid       = !rst && (count != '0);
    pop            = id_valid && id_ready;
    // Words owed to a flushed fetch stream are swallowed; a redirect also drops this cycle's word.
    push           = imem_rsp_valid && (discard == '0) && !redirect_valid;
    id_instr       = id_valid ? q_instr[q_head] : '0;
    id_pc          = id_valid ? q_pc[q_head]    : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
      q_head   <= '0;
      q_tail   <= '0;
      f_head   <= '0;
      f_tail   <= '0;
    end else begin
      if (accept)         f_tail <= ptr_inc(f_tail);
      if (imem_rsp_valid) f_head <= ptr_inc(f_head);

      if (accept && !imem_rsp_valid)      inflight <= inflight + cnt_t'(1);
      else if (!accept && imem_rsp_valid) inflight <= inflight - cnt_t'(1);

      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        count    <= '0;
        q_head   <= '0;
        q_tail   <= '0;
        // Every request still outstanding after this edge belongs to the old stream.
        discard  <= imem_rsp_valid ? inflight - cnt_t'(1) : inflight;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (imem_rsp_valid && (discard != '0)) discard <= discard - cnt_t'(1);
        if (push) q_tail <= ptr_inc(q_tail);
        if (pop)  q_head <= ptr_inc(q_head);
        if (push && !pop)      count <= count + cnt_t'(1);
        else if (!push && pop) count <= count - cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) f_pc[f_tail] <= fetch_pc;
    if (push) begin
      q_instr[q_tail] <= imem_rsp_data;
      q_pc[q_tail]    <= f_pc[f_head];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && (count == DEPTH_C)));
      assert ((inflight != '0) || (discard == '0));
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a behavioural memory plus an epoch-tagged reference queue
// predict every cycle's request and decode-side outputs.
module tb_fetch_queue;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;

  always #5 clk = ~clk;

  fetch_queue #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
  );

  typedef struct { logic [31:0] addr; int due; int epoch; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  mreq_t       mem_q[$];
  ent_t        ref_q[$];
  logic [31:0] got_pc[$];
  logic [31:0] model_pc;
  int errors = 0, checks = 0, cyc = 0, epoch = 0, lat = 1, accepts = 0;
  int first_req_cyc = -1, first_iv_cyc = -1;
  bit ready_rand = 1'b0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic cycle(input logic redir, input logic [31:0] rpc);
    logic exp_rv, exp_iv, rsp_now, acc, pop;
    mreq_t m;
    ent_t e;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    rsp_now        = !rst && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? word_of(mem_q[0].addr) : 32'h0;
    #1;
    exp_rv = !rst && !redir && ((ref_q.size() + mem_q.size()) < DEPTH);
    exp_iv = !rst && (ref_q.size() > 0);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("imem_addr", imem_addr, model_pc);
    chk("id_valid", 32'(id_valid), 32'(exp_iv));
    if (exp_iv) begin
      chk("id_pc", id_pc, ref_q[0].pc);
      chk("id_instr", id_instr, ref_q[0].instr);
    end else if (rst) begin
      chk("rst_id_pc", id_pc, 32'h0);
      chk("rst_id_instr", id_instr, 32'h0);
    end
    if (!rst && imem_req_valid && imem_req_ready) begin
      accepts++;
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end
    if (!rst && id_valid) begin
      if (first_iv_cyc < 0) first_iv_cyc = cyc;
      if (id_ready) got_pc.push_back(id_pc);
    end
    acc = exp_rv && imem_req_ready;
    pop = exp_iv && id_ready;
    if (rst) begin
      mem_q.delete();
      ref_q.delete();
      model_pc = RST_PC;
    end else begin
      if (rsp_now) begin
        m = mem_q.pop_front();
        if (m.epoch == epoch) ref_q.push_back('{pc: m.addr, instr: word_of(m.addr)});
      end
      if (pop) e = ref_q.pop_front();
      if (acc) begin
        mem_q.push_back('{addr: model_pc, due: cyc + lat, epoch: epoch});
        model_pc = model_pc + 32'd4;
      end
      if (redir) begin
        ref_q.delete();
        epoch++;
        model_pc = {rpc[31:2], 2'b00};
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    bit reached;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; id_ready = 1'b0;
    model_pc = RST_PC;
    @(negedge clk);
    repeat (2) cycle(1'b0, 32'h0);

    // Release with decode stalled: only DEPTH requests may go out.
    rst = 1'b0; lat = 1; accepts = 0;
    repeat (10) cycle(1'b0, 32'h0);
    chk("stall_accepts", 32'(accepts), 32'd4);
    chk("stall_head_pc", id_pc, 32'h0000_0100);
    chk("first_iv_latency", 32'(first_iv_cyc - first_req_cyc), 32'd2);

    // Drain with a 1-cycle memory: one instruction per cycle, strictly +4.
    id_ready = 1'b1;
    got_pc.delete();
    repeat (20) cycle(1'b0, 32'h0);
    chk("stream_len", 32'(got_pc.size()), 32'd20);
    for (int i = 0; i < got_pc.size(); i++)
      chk("stream_pc", got_pc[i], 32'h0000_0100 + 32'(4 * i));

    // Redirect with three requests outstanding on a 3-cycle memory.
    lat = 3;
    reached = 1'b0;
    for (int i = 0; i < 50 && !reached; i++) begin
      if (mem_q.size() == 3) reached = 1'b1;
      else cycle(1'b0, 32'h0);
    end
    chk("reach_3_inflight", 32'(reached), 32'd1);
    got_pc.delete();
    cycle(1'b1, 32'h0000_2002);
    chk("redir_id_valid", 32'(id_valid), 32'd0);
    for (int i = 0; i < 30 && got_pc.size() == 0; i++) cycle(1'b0, 32'h0);
    chk("redir_first_pc", (got_pc.size() > 0) ? got_pc[0] : 32'hFFFF_FFFF, 32'h0000_2000);

    // Address wrap past the top of memory.
    lat = 1;
    cycle(1'b1, 32'hFFFF_FFF8);
    got_pc.delete();
    repeat (10) cycle(1'b0, 32'h0);
    chk("wrap_pc0", (got_pc.size() > 0) ? got_pc[0] : 32'h1, 32'hFFFF_FFF8);
    chk("wrap_pc1", (got_pc.size() > 1) ? got_pc[1] : 32'h1, 32'hFFFF_FFFC);
    chk("wrap_pc2", (got_pc.size() > 2) ? got_pc[2] : 32'h1, 32'h0000_0000);

    // Random memory back-pressure and decode stalls, 3-cycle memory.
    ready_rand = 1'b1;
    lat = 3;
    for (int i = 0; i < 300; i++) begin
      id_ready = ($urandom_range(0, 3) != 0);
      cycle(1'b0, 32'h0);
    end

    // Random redirects with varying memory latency.
    for (int i = 0; i < 400; i++) begin
      id_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) begin
        lat = $urandom_range(1, 3);
        cycle(1'b1, $urandom);
      end else begin
        cycle(1'b0, 32'h0);
      end
    end

    // Reset in the middle of traffic; memory is reset alongside.
    rst = 1'b1;
    cycle(1'b0, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      id_ready = ($urandom_range(0, 3) != 0);
      cycle(1'b0, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
